// File: rtl/bxclk_burst_controller.sv
// bxclk_burst_controller: sequencer that validates software bxclk settings,
// drives the bxclks_generators config/enable and runs bursts or continuous runs.
//
// Ports:
//   clk, reset            400 MHz pl_clk1, async active-high reset
//   cfg_period/delay/sign requested generator settings
//   cfg_burst_len         periods to run, 0 = continuous
//   start, stop           single-cycle run control pulses
//   cfg_update            live reconfiguration pulse (BXCLK_CTRL_RECONFIG_EN only)
//   gen_clk_counter       counter fed back from the generator
//   gen_enable/period/delay/delay_sign  generator drive
//   busy, done, cfg_err, periods_done   status
//
// Optional feature macro: BXCLK_CTRL_RECONFIG_EN (shadowed live reconfig).

module bxclk_burst_controller #(
    parameter int BURST_W    = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         cfg_period,
    input  logic [4:0]         cfg_delay,
    input  logic               cfg_delay_sign,
    input  logic [BURST_W-1:0] cfg_burst_len,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_update,
    input  logic [5:0]         gen_clk_counter,
    output logic               gen_enable,
    output logic [5:0]         gen_period,
    output logic [4:0]         gen_delay,
    output logic               gen_delay_sign,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [BURST_W-1:0] periods_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STOP
    } state_t;

    localparam logic [5:0]         MIN_P = 6'(MIN_PERIOD);
    localparam logic [BURST_W-1:0] ONE   = BURST_W'(1);

    state_t state_q, state_d;

    logic               en_q, en_d;
    logic [5:0]         per_q, per_d;
    logic [4:0]         dly_q, dly_d;
    logic               sgn_q, sgn_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] pd_q, pd_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               stop_pend_q, stop_pend_d;

`ifdef BXCLK_CTRL_RECONFIG_EN
    logic [5:0]         sh_per_q, sh_per_d;
    logic [4:0]         sh_dly_q, sh_dly_d;
    logic               sh_sgn_q, sh_sgn_d;
    logic               upd_q, upd_d;
    // Blocks a false boundary in the cycle right after a wrap, when the
    // counter sits at the old period which may equal new_period-1.
    logic               after_b_q, after_b_d;
`else
    logic               unused_cfg_update;
    assign unused_cfg_update = cfg_update;
`endif

    logic               cfg_ok;
    logic               at_bnd;
    logic               run_last;
    logic [BURST_W-1:0] pd_sat;

    assign cfg_ok = (cfg_period >= MIN_P) &&
                    ({1'b0, cfg_delay} < cfg_period);

`ifdef BXCLK_CTRL_RECONFIG_EN
    assign at_bnd = en_q && !after_b_q &&
                    (gen_clk_counter == per_q - 6'd1);
`else
    assign at_bnd = en_q && (gen_clk_counter == per_q - 6'd1);
`endif

    // A stop arriving on the boundary itself still ends the run there.
    assign run_last = ((len_q != '0) && (pd_q == len_q - ONE)) ||
                      stop_pend_q || stop;

    assign pd_sat = (pd_q == '1) ? pd_q : pd_q + ONE;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start && cfg_ok) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN:  if (at_bnd && run_last) state_d = S_STOP;
            S_STOP: if (gen_clk_counter == 6'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        en_d        = en_q;
        per_d       = per_q;
        dly_d       = dly_q;
        sgn_d       = sgn_q;
        len_d       = len_q;
        pd_d        = pd_q;
        err_d       = err_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
`ifdef BXCLK_CTRL_RECONFIG_EN
        sh_per_d    = sh_per_q;
        sh_dly_d    = sh_dly_q;
        sh_sgn_d    = sh_sgn_q;
        upd_d       = upd_q;
        after_b_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        per_d       = cfg_period;
                        dly_d       = cfg_delay;
                        sgn_d       = cfg_delay_sign;
                        len_d       = cfg_burst_len;
                        pd_d        = '0;
                        err_d       = 1'b0;
                        stop_pend_d = 1'b0;
`ifdef BXCLK_CTRL_RECONFIG_EN
                        upd_d       = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // gen_* were latched a cycle earlier, so they are settled
                en_d = 1'b1;
            end
            S_RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (at_bnd) begin
                    pd_d = pd_sat;
                    // Dropping enable here lets the generator finish
                    // the final period before its counter returns to 0.
                    if (run_last) en_d = 1'b0;
                end
`ifdef BXCLK_CTRL_RECONFIG_EN
                after_b_d = at_bnd;
                if (at_bnd && upd_q) begin
                    per_d = sh_per_q;
                    dly_d = sh_dly_q;
                    sgn_d = sh_sgn_q;
                    upd_d = 1'b0;
                end
                if (cfg_update) begin
                    if (cfg_ok) begin
                        sh_per_d = cfg_period;
                        sh_dly_d = cfg_delay;
                        sh_sgn_d = cfg_delay_sign;
                        upd_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
            end
            S_STOP: begin
                if (gen_clk_counter == 6'd0) begin
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            per_q       <= 6'd10;
            dly_q       <= 5'd0;
            sgn_q       <= 1'b0;
            len_q       <= '0;
            pd_q        <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            en_q        <= en_d;
            per_q       <= per_d;
            dly_q       <= dly_d;
            sgn_q       <= sgn_d;
            len_q       <= len_d;
            pd_q        <= pd_d;
            err_q       <= err_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef BXCLK_CTRL_RECONFIG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_per_q  <= 6'd10;
            sh_dly_q  <= 5'd0;
            sh_sgn_q  <= 1'b0;
            upd_q     <= 1'b0;
            after_b_q <= 1'b0;
        end else begin
            sh_per_q  <= sh_per_d;
            sh_dly_q  <= sh_dly_d;
            sh_sgn_q  <= sh_sgn_d;
            upd_q     <= upd_d;
            after_b_q <= after_b_d;
        end
    end
`endif

    assign gen_enable     = en_q;
    assign gen_period     = per_q;
    assign gen_delay      = dly_q;
    assign gen_delay_sign = sgn_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign cfg_err        = err_q;
    assign periods_done   = pd_q;

endmodule

// File: tb/tb_bxclk_burst_controller.sv
// tb_bxclk_burst_controller: self-checking bench with a generator model,
// a timeline-based reference model, directed scenarios and random runs.

module tb_bxclk_burst_controller;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    cfg_period;
    logic [4:0]    cfg_delay;
    logic          cfg_delay_sign;
    logic [BW-1:0] cfg_burst_len;
    logic          start, stop, cfg_update;
    logic [5:0]    gen_clk_counter;
    logic          gen_enable;
    logic [5:0]    gen_period;
    logic [4:0]    gen_delay;
    logic          gen_delay_sign;
    logic          busy, done, cfg_err;
    logic [BW-1:0] periods_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bxclk_burst_controller #(.BURST_W(BW), .MIN_PERIOD(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_period     (cfg_period),
        .cfg_delay      (cfg_delay),
        .cfg_delay_sign (cfg_delay_sign),
        .cfg_burst_len  (cfg_burst_len),
        .start          (start),
        .stop           (stop),
        .cfg_update     (cfg_update),
        .gen_clk_counter(gen_clk_counter),
        .gen_enable     (gen_enable),
        .gen_period     (gen_period),
        .gen_delay      (gen_delay),
        .gen_delay_sign (gen_delay_sign),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .periods_done   (periods_done)
    );

    // Generator stand-in: counts 0..p-1 in the first period, then p,1..p-1;
    // latches its period at each wrap; after enable drops it runs to p then 0.
    logic [5:0] g_cnt, g_p;
    assign gen_clk_counter = g_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            g_cnt <= 6'd0;
            g_p   <= 6'd10;
        end else if (gen_enable) begin
            if (g_cnt == 6'd0 || g_cnt == g_p) begin
                g_cnt <= 6'd1;
                g_p   <= gen_period;
            end else begin
                g_cnt <= g_cnt + 6'd1;
            end
        end else if (g_cnt == g_p) begin
            g_cnt <= 6'd0;
        end else if (g_cnt != 6'd0) begin
            g_cnt <= g_cnt + 6'd1;
        end
    end

    // Reference model: timeline in edges since an accepted start.
    // Enable rises at edge 1, boundaries every m_per edges, done at end+2.
    bit            m_active, m_term, m_stop_req, m_upd;
    int            t, nb, e_edge;
    logic          m_en, m_done, m_err, m_sign, s_sign;
    logic [5:0]    m_per, s_per;
    logic [4:0]    m_del, s_del;
    logic [BW-1:0] m_len, m_pd;
    bit            fin;

    function automatic bit valid_cfg(logic [5:0] p, logic [4:0] d);
        return (p >= 6'd2) && ({1'b0, d} < p);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0; m_term = 0; m_stop_req = 0; m_upd = 0;
            m_en = 0; m_done = 0; m_err = 0;
            m_per = 6'd10; m_del = 5'd0; m_sign = 0;
            m_len = '0; m_pd = '0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    if (valid_cfg(cfg_period, cfg_delay)) begin
                        m_per = cfg_period; m_del = cfg_delay;
                        m_sign = cfg_delay_sign; m_len = cfg_burst_len;
                        m_pd = '0; m_err = 0; m_active = 1; t = 0;
                        m_term = 0; m_stop_req = 0; m_upd = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end else begin
                t++;
                if (t == 1) begin
                    m_en = 1;
                    nb = 1 + int'(m_per);
                end else if (!m_term) begin
                    if (t == nb) begin
                        if (m_pd != {BW{1'b1}}) m_pd = m_pd + 1'b1;
                        fin = ((m_len != 0) && (m_pd == m_len)) ||
                              m_stop_req || stop;
`ifdef BXCLK_CTRL_RECONFIG_EN
                        if (m_upd) begin
                            m_per = s_per; m_del = s_del;
                            m_sign = s_sign; m_upd = 0;
                        end
`endif
                        nb = t + int'(m_per);
                        if (fin) begin
                            m_term = 1; m_en = 0; e_edge = t;
                        end
                    end
                    if (stop) m_stop_req = 1;
`ifdef BXCLK_CTRL_RECONFIG_EN
                    if (cfg_update) begin
                        if (valid_cfg(cfg_period, cfg_delay)) begin
                            s_per = cfg_period; s_del = cfg_delay;
                            s_sign = cfg_delay_sign; m_upd = 1;
                        end else begin
                            m_err = 1;
                        end
                    end
`endif
                end else if (t == e_edge + 2) begin
                    m_done = 1;
                    m_active = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("cmp_enable", 32'(gen_enable), 32'(m_en));
            chk("cmp_busy", 32'(busy), 32'(m_active));
            chk("cmp_done", 32'(done), 32'(m_done));
            chk("cmp_cfg_err", 32'(cfg_err), 32'(m_err));
            chk("cmp_periods_done", 32'(periods_done), 32'(m_pd));
            chk("cmp_period", 32'(gen_period), 32'(m_per));
            chk("cmp_delay", 32'(gen_delay), 32'(m_del));
            chk("cmp_sign", 32'(gen_delay_sign), 32'(m_sign));
        end
    end

    // Measurement monitor for the literal checks.
    logic prev_en = 1'b0;
    int   en_run = 0, en_len = 0, sf = 0, gap = -1, done_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_en = 0; en_run = 0;
        end else begin
            if (gen_enable) en_run++;
            if (prev_en && !gen_enable) begin
                en_len = en_run; en_run = 0; sf = 0;
            end else begin
                sf++;
            end
            if (done) begin
                done_cnt++; gap = sf;
            end
            prev_en = gen_enable;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int p, input int d, input int s,
                           input int l);
        cfg_period     = 6'(p);
        cfg_delay      = 5'(d);
        cfg_delay_sign = 1'(s);
        cfg_burst_len  = BW'(l);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int c = 0;
        while (!done && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_pd_cnt(input int pd, input int cnt,
                               input int maxc);
        int c = 0;
        while (!(periods_done == BW'(pd) && g_cnt == 6'(cnt))
               && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("wait_point", 32'(c < maxc), 32'd1);
    endtask

    int d0;
    time t1, t2, t3;

    initial begin
        reset = 1'b1;
        start = 0; stop = 0; cfg_update = 0;
        set_cfg(10, 0, 0, 0);
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_enable", 32'(gen_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_pd", 32'(periods_done), 32'd0);
        chk("rst_period", 32'(gen_period), 32'd10);
        chk("rst_delay", 32'(gen_delay), 32'd0);
        chk("rst_sign", 32'(gen_delay_sign), 32'd0);

        // Burst of 3 x 10
        set_cfg(10, 0, 0, 3);
        d0 = done_cnt;
        pulse_start;
        wait_done(200);
        tick(2);
        chk("burst_en_len", 32'(en_len), 32'd30);
        chk("burst_done_gap", 32'(gap), 32'd2);
        chk("burst_pd", 32'(periods_done), 32'd3);
        chk("burst_done_once", 32'(done_cnt - d0), 32'd1);

        // Continuous, stop at counter 3 of the 4th period
        set_cfg(8, 2, 1, 0);
        pulse_start;
        wait_pd_cnt(3, 3, 200);
        pulse_stop;
        wait_done(100);
        tick(2);
        chk("cont_pd", 32'(periods_done), 32'd4);
        chk("cont_en_len", 32'(en_len), 32'd32);
        chk("cont_done_gap", 32'(gap), 32'd2);

        // Invalid configurations
        set_cfg(1, 0, 0, 2);
        pulse_start;
        chk("inv_p1_err", 32'(cfg_err), 32'd1);
        chk("inv_p1_busy", 32'(busy), 32'd0);
        chk("inv_p1_en", 32'(gen_enable), 32'd0);
        set_cfg(6, 5, 0, 1);
        pulse_start;
        chk("valid_clears_err", 32'(cfg_err), 32'd0);
        chk("valid_busy", 32'(busy), 32'd1);
        wait_done(100);
        tick(1);
        set_cfg(12, 12, 0, 1);
        pulse_start;
        chk("inv_d12_err", 32'(cfg_err), 32'd1);
        chk("inv_d12_period", 32'(gen_period), 32'd6);
        chk("inv_d12_busy", 32'(busy), 32'd0);

        // Stop on the final boundary plus a start during RUN
        set_cfg(4, 1, 0, 2);
        d0 = done_cnt;
        pulse_start;
        tick(2);
        pulse_start;
        wait_pd_cnt(1, 3, 100);
        pulse_stop;
        wait_done(100);
        tick(5);
        chk("coin_done_once", 32'(done_cnt - d0), 32'd1);
        chk("coin_pd", 32'(periods_done), 32'd2);
        chk("coin_busy", 32'(busy), 32'd0);
        chk("coin_en_len", 32'(en_len), 32'd8);

        // Reset mid-run
        set_cfg(10, 3, 0, 5);
        pulse_start;
        tick(18);
        #2 reset = 1'b1;
        #1;
        chk("amid_enable", 32'(gen_enable), 32'd0);
        chk("amid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("amid_pd", 32'(periods_done), 32'd0);
        chk("amid_period", 32'(gen_period), 32'd10);
        chk("amid_delay", 32'(gen_delay), 32'd0);
        chk("amid_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick(1);
        set_cfg(5, 1, 0, 2);
        pulse_start;
        wait_done(100);
        tick(1);
        chk("post_rst_pd", 32'(periods_done), 32'd2);
        chk("post_rst_en_len", 32'(en_len), 32'd10);

`ifdef BXCLK_CTRL_RECONFIG_EN
        set_cfg(10, 2, 0, 0);
        pulse_start;
        wait_pd_cnt(1, 4, 100);
        t1 = $time;
        cfg_period = 6'd20; cfg_delay = 5'd3; cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
        wait_pd_cnt(2, 1, 100);
        t2 = $time;
        wait_pd_cnt(3, 1, 100);
        t3 = $time;
        chk("rcfg_gap1", 32'((t3 - t2) / 10), 32'd20);
        chk("rcfg_old_done", 32'((t2 - t1) / 10), 32'd7);
        chk("rcfg_period", 32'(gen_period), 32'd20);
        cfg_period = 6'd0; cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
        tick(1);
        chk("rcfg_bad_err", 32'(cfg_err), 32'd1);
        wait_pd_cnt(4, 1, 100);
        chk("rcfg_keep_period", 32'(gen_period), 32'd20);
        pulse_stop;
        wait_done(100);
        tick(1);
`endif

        // Random runs checked against the model every cycle
        for (int r = 0; r < 40; r++) begin
            int bl;
            bl = int'($urandom_range(0, 5));
            set_cfg(int'($urandom_range(0, 24)),
                    int'($urandom_range(0, 24)),
                    int'($urandom_range(0, 1)), bl);
            pulse_start;
            if (busy) begin
                int c = 0;
                while (busy && c < 800) begin
                    stop = ($urandom_range(0, 29) == 0) ||
                           (bl == 0 && c >= 60);
                    start = ($urandom_range(0, 19) == 0);
                    cfg_update = ($urandom_range(0, 9) == 0);
                    set_cfg(int'($urandom_range(0, 24)),
                            int'($urandom_range(0, 24)),
                            int'($urandom_range(0, 1)), bl);
                    @(negedge clk);
                    c++;
                end
                start = 0; stop = 0; cfg_update = 0;
                chk("rand_run_ends", 32'(busy), 32'd0);
                if (busy) begin
                    reset = 1'b1;
                    tick(1);
                    reset = 1'b0;
                end
            end
            tick(int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
